add16_share_ctrl: RTL and testbench

//  Shares one external ADD16bit between two requesters and sequences wide adds.

---
 rtl/add16_share_ctrl.sv | 138 +++++++++++++
 tb/tb_add16_share_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add16_share_ctrl.sv
// Arbitrates two requesters onto one shared 16-bit adder and sequences a
// NUM_SLICES-wide add through it, low slice first, chaining the carry.
module add16_share_ctrl #(
    parameter int NUM_SLICES = 2,
    parameter bit RR_INIT    = 1'b0,
    localparam int W         = 16 * NUM_SLICES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic         cin0,
    input  logic         req1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    input  logic         cin1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         busy,
    output logic         res_valid,
    output logic         res_id,
    output logic [W-1:0] res_sum,
    output logic         res_cout,
    output logic [15:0]  add_a,
    output logic [15:0]  add_b,
    output logic         add_cin,
    input  logic [15:0]  add_sum,
    input  logic         add_cout
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state_q;
    logic         prio_q;
    logic         owner_q;
    logic         carry_q;
    logic [1:0]   slice_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;
    logic [W-1:0] res_sum_q;
    logic         res_cout_q;
    logic         res_id_q;
    logic         res_valid_q;
    logic         gnt0_q;
    logic         gnt1_q;

    logic         pick1;
    logic         in_run;
    logic         last_slice;
    logic [15:0]  a_sl [4];
    logic [15:0]  b_sl [4];

    // Slice views padded to four entries so slice_q can index them directly.
    for (genvar gi = 0; gi < 4; gi++) begin : g_slice
        if (gi < NUM_SLICES) begin : g_live
            assign a_sl[gi] = a_q[16*gi +: 16];
            assign b_sl[gi] = b_q[16*gi +: 16];
            assign acc_d[16*gi +: 16] = (slice_q == 2'(gi)) ? add_sum : acc_q[16*gi +: 16];
        end else begin : g_pad
            assign a_sl[gi] = '0;
            assign b_sl[gi] = '0;
        end
    end

    // prio_q names the requester that wins a tie.
    assign pick1      = req1 & (~req0 | prio_q);
    assign in_run     = (state_q == RUN);
    assign last_slice = (slice_q == 2'(NUM_SLICES - 1));

    assign add_a   = in_run ? a_sl[slice_q] : 16'h0000;
    assign add_b   = in_run ? b_sl[slice_q] : 16'h0000;
    assign add_cin = in_run & carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prio_q      <= RR_INIT;
            owner_q     <= 1'b0;
            carry_q     <= 1'b0;
            slice_q     <= 2'd0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            res_id_q    <= 1'b0;
            res_valid_q <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
        end else begin
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            res_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 | req1) begin
                        owner_q <= pick1;
                        a_q     <= pick1 ? a1 : a0;
                        b_q     <= pick1 ? b1 : b0;
                        carry_q <= pick1 ? cin1 : cin0;
                        slice_q <= 2'd0;
                        gnt0_q  <= ~pick1;
                        gnt1_q  <= pick1;
                        prio_q  <= ~pick1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= add_cout;
                    slice_q <= slice_q + 2'd1;
                    // Published result changes only when a full operation completes.
                    if (last_slice) begin
                        res_sum_q   <= acc_d;
                        res_cout_q  <= add_cout;
                        res_id_q    <= owner_q;
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign busy      = (state_q != IDLE);
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;

endmodule

// File: tb/tb_add16_share_ctrl.sv
// Scoreboarded bench: a 2-slice controller with a behavioural adder on its
// adder ports, plus a 1-slice instance for the single-slice case.
module tb_add16_share_ctrl;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic req0 = 0, req1 = 0, cin0 = 0, cin1 = 0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic gnt0, gnt1, busy, res_valid, res_id, res_cout;
    logic [W-1:0] res_sum;
    logic [15:0] add_a, add_b, add_sum;
    logic add_cin, add_cout;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);

    add16_share_ctrl #(.NUM_SLICES(2), .RR_INIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
        .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
        .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum), .res_cout(res_cout),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    logic req0_s = 0, req1_s = 0, cin0_s = 0, cin1_s = 0;
    logic [15:0] a0_s = '0, b0_s = '0, a1_s = '0, b1_s = '0;
    logic gnt0_s, gnt1_s, busy_s, res_valid_s, res_id_s, res_cout_s;
    logic [15:0] res_sum_s, add_a_s, add_b_s, add_sum_s;
    logic add_cin_s, add_cout_s;

    assign {add_cout_s, add_sum_s} = {1'b0, add_a_s} + {1'b0, add_b_s} + 17'(add_cin_s);

    add16_share_ctrl #(.NUM_SLICES(1), .RR_INIT(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0_s), .a0(a0_s), .b0(b0_s), .cin0(cin0_s),
        .req1(req1_s), .a1(a1_s), .b1(b1_s), .cin1(cin1_s),
        .gnt0(gnt0_s), .gnt1(gnt1_s), .busy(busy_s),
        .res_valid(res_valid_s), .res_id(res_id_s), .res_sum(res_sum_s), .res_cout(res_cout_s),
        .add_a(add_a_s), .add_b(add_b_s), .add_cin(add_cin_s),
        .add_sum(add_sum_s), .add_cout(add_cout_s)
    );

    int total = 0;
    int passed = 0;
    logic [W:0] q0[$];
    logic [W:0] q1[$];

    // Result monitor: every res_valid pops the owning requester's queue.
    always begin : mon
        logic [W:0] exp_v;
        @(posedge clk);
        #1;
        if (res_valid) begin
            total++;
            if ((res_id && q1.size() == 0) || (!res_id && q0.size() == 0)) begin
                $display("FAIL unexpected_result id=%0d got sum=%h cout=%0d, none pending", res_id, res_sum, res_cout);
            end else begin
                exp_v = res_id ? q1.pop_front() : q0.pop_front();
                if ({res_cout, res_sum} !== exp_v)
                    $display("FAIL result id=%0d got cout=%0d sum=%h want cout=%0d sum=%h",
                             res_id, res_cout, res_sum, exp_v[W], exp_v[W-1:0]);
                else
                    passed++;
            end
        end
    end

    task automatic wait_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit w0, input bit w1,
                         input logic [W-1:0] x0, input logic [W-1:0] y0, input logic k0,
                         input logic [W-1:0] x1, input logic [W-1:0] y1, input logic k1,
                         input int first);
        bit p0, p1;
        int n, order, want;
        p0 = w0; p1 = w1; n = 0; order = 0;
        if (w0) begin
            a0 = x0; b0 = y0; cin0 = k0; req0 = 1'b1;
            q0.push_back({1'b0, x0} + {1'b0, y0} + 33'(k0));
        end
        if (w1) begin
            a1 = x1; b1 = y1; cin1 = k1; req1 = 1'b1;
            q1.push_back({1'b0, x1} + {1'b0, y1} + 33'(k1));
        end
        while ((p0 || p1) && n < 40) begin
            wait_clk();
            n++;
            if (gnt0 || gnt1) begin
                want = (order == 0) ? first : 1 - first;
                if (first >= 0) begin
                    total++;
                    if (gnt1 !== want[0] || (gnt0 && gnt1))
                        $display("FAIL grant_order #%0d got gnt0=%0d gnt1=%0d want requester %0d", order, gnt0, gnt1, want);
                    else
                        passed++;
                end
                order++;
                if (gnt0) begin req0 = 1'b0; p0 = 0; end
                if (gnt1) begin req1 = 1'b0; p1 = 0; end
            end
        end
        if (p0 || p1) begin
            total++;
            $display("FAIL grant_timeout got pending0=%0d pending1=%0d want both granted", p0, p1);
            req0 = 1'b0; req1 = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 30) begin
            wait_clk();
            n++;
        end
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            $display("FAIL drain got pending0=%0d pending1=%0d want 0", q0.size(), q1.size());
            q0.delete(); q1.delete();
        end else begin
            passed++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({gnt0, gnt1, busy, res_valid, res_id, res_cout, res_sum, add_a, add_b, add_cin} !== '0)
            $display("FAIL reset_outputs got gnt=%0d%0d busy=%0d rv=%0d sum=%h add_a=%h want all 0",
                     gnt0, gnt1, busy, res_valid, res_sum, add_a);
        else
            passed++;
        total++;
        if ({gnt0_s, busy_s, res_valid_s, res_sum_s, res_cout_s, add_a_s} !== '0)
            $display("FAIL reset_outputs_1slice got busy=%0d rv=%0d sum=%h want all 0", busy_s, res_valid_s, res_sum_s);
        else
            passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        a0 = 32'h0000FFFF; b0 = 32'h1; cin0 = 1'b0; req0 = 1'b1;
        q0.push_back(33'h0_0001_0000);
        wait_clk();
        total++;
        if (gnt0 !== 1'b1 || busy !== 1'b1 || add_a !== 16'hFFFF || add_b !== 16'h0001 || add_cin !== 1'b0)
            $display("FAIL basic_slice0 got gnt0=%0d busy=%0d add_a=%h add_b=%h cin=%0d want 1 1 ffff 0001 0",
                     gnt0, busy, add_a, add_b, add_cin);
        else
            passed++;
        req0 = 1'b0;
        wait_clk();
        total++;
        if (gnt0 !== 1'b0 || add_a !== 16'h0000 || add_b !== 16'h0000 || add_cin !== 1'b1 || res_valid !== 1'b0)
            $display("FAIL basic_slice1 got gnt0=%0d add_a=%h add_b=%h cin=%0d rv=%0d want 0 0000 0000 1 0",
                     gnt0, add_a, add_b, add_cin, res_valid);
        else
            passed++;
        wait_clk();
        total++;
        if (res_valid !== 1'b1 || res_id !== 1'b0 || add_a !== 16'h0000)
            $display("FAIL basic_done got rv=%0d id=%0d add_a=%h want 1 0 0000", res_valid, res_id, add_a);
        else
            passed++;
        wait_clk();
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || res_sum !== 32'h00010000 || res_cout !== 1'b0)
            $display("FAIL basic_hold got rv=%0d busy=%0d sum=%h cout=%0d want 0 0 00010000 0",
                     res_valid, busy, res_sum, res_cout);
        else
            passed++;
    endtask

    task automatic test_carry();
        issue(0, 1, '0, '0, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
        drain();
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0;
        wait_clk();
        rst_n = 1'b1;
        issue(1, 1, 32'h11111111, 32'h22222222, 1'b0, 32'h80000000, 32'h80000000, 1'b0, 0);
        issue(1, 1, 32'hDEADBEEF, 32'h01010101, 1'b1, 32'h0000FFFF, 32'h0000FFFF, 1'b1, 0);
        drain();
    endtask

    task automatic test_reset_mid();
        a0 = 32'h12345678; b0 = 32'h00010001; cin0 = 1'b0; req0 = 1'b1;
        wait_clk();
        total++;
        if (gnt0 !== 1'b1)
            $display("FAIL midrst_grant got gnt0=%0d want 1", gnt0);
        else
            passed++;
        req0 = 1'b0;
        wait_clk();
        total++;
        if (add_a !== 16'h1234 || add_b !== 16'h0001)
            $display("FAIL midrst_slice1 got add_a=%h add_b=%h want 1234 0001", add_a, add_b);
        else
            passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({gnt0, gnt1, busy, res_valid, res_id, res_cout, res_sum, add_a, add_b, add_cin} !== '0)
            $display("FAIL midrst_outputs got busy=%0d rv=%0d sum=%h add_a=%h cin=%0d want all 0",
                     busy, res_valid, res_sum, add_a, add_cin);
        else
            passed++;
        repeat (2) begin
            wait_clk();
            total++;
            if (res_valid !== 1'b0 || busy !== 1'b0)
                $display("FAIL midrst_quiet got rv=%0d busy=%0d want 0 0", res_valid, busy);
            else
                passed++;
        end
        rst_n = 1'b1;
        wait_clk();
        issue(1, 0, 32'h0F0F0F0F, 32'hF0F0F0F1, 1'b0, '0, '0, 1'b0, 0);
        drain();
    endtask

    task automatic test_single_slice();
        a0_s = 16'h8000; b0_s = 16'h8000; cin0_s = 1'b0; req0_s = 1'b1;
        wait_clk();
        total++;
        if (gnt0_s !== 1'b1 || res_valid_s !== 1'b0 || add_a_s !== 16'h8000 || add_b_s !== 16'h8000)
            $display("FAIL single_run got gnt0=%0d rv=%0d add_a=%h add_b=%h want 1 0 8000 8000",
                     gnt0_s, res_valid_s, add_a_s, add_b_s);
        else
            passed++;
        req0_s = 1'b0;
        wait_clk();
        total++;
        if (res_valid_s !== 1'b1 || res_sum_s !== 16'h0000 || res_cout_s !== 1'b1 || res_id_s !== 1'b0)
            $display("FAIL single_result got rv=%0d sum=%h cout=%0d id=%0d want 1 0000 1 0",
                     res_valid_s, res_sum_s, res_cout_s, res_id_s);
        else
            passed++;
        wait_clk();
        total++;
        if (res_valid_s !== 1'b0 || busy_s !== 1'b0)
            $display("FAIL single_idle got rv=%0d busy=%0d want 0 0", res_valid_s, busy_s);
        else
            passed++;
    endtask

    task automatic test_random();
        logic [W-1:0] x0, y0, x1, y1;
        for (int i = 0; i < 1000; i++) begin
            x0 = $urandom; y0 = $urandom; x1 = $urandom; y1 = $urandom;
            if (i % 8 == 0) begin x0 = '1; y1 = '1; end
            issue(1, 1, x0, y0, 1'($urandom_range(0, 1)), x1, y1, 1'($urandom_range(0, 1)), -1);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_round_robin();
        test_reset_mid();
        test_single_slice();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
